// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage LoongArch pipeline.
// Latches the execute-to-memory bus, captures the synchronous data-SRAM read
// word, aligns and extends load results, and publishes the write-back bus,
// the decode forwarding bus and the exception/ERTN indications.
//
// Build option: define MEM_LOAD_FWD_EN to advertise loads held in this stage
// as forwardable (load bit of MEM_wr_bus stays low). Without it, the load bit
// is raised so decode waits until the load reaches write-back.
module mem_stage #(
    parameter int BUS_IN_W  = 189,
    parameter int BUS_OUT_W = 188
) (
    input  logic                 clk,
    input  logic                 resetn,

    input  logic                 EXE_to_MEM_valid,
    output logic                 MEM_allow_in,
    input  logic [BUS_IN_W-1:0]  EXE_to_MEM_bus,
    input  logic [31:0]          data_sram_rdata,

    output logic                 MEM_to_WB_valid,
    input  logic                 WB_allow_in,
    output logic [BUS_OUT_W-1:0] MEM_to_WB_bus,

    output logic [38:0]          MEM_wr_bus,
    output logic                 MEM_ex,
    output logic                 MEM_ertn,

    input  logic                 wb_ex,
    input  logic                 ertn_flush
);

    // Load opcodes, matched on inst[31:22].
    localparam logic [9:0] OP_LD_B  = 10'b0010100000;
    localparam logic [9:0] OP_LD_H  = 10'b0010100001;
    localparam logic [9:0] OP_LD_W  = 10'b0010100010;
    localparam logic [9:0] OP_LD_BU = 10'b0010101000;
    localparam logic [9:0] OP_LD_HU = 10'b0010101001;

`ifdef MEM_LOAD_FWD_EN
    localparam logic LOAD_HAZ = 1'b0;
`else
    localparam logic LOAD_HAZ = 1'b1;
`endif

    // Stage state.
    logic                mem_valid_q,  mem_valid_d;
    logic [BUS_IN_W-1:0] bus_q,        bus_d;
    logic [31:0]         rdata_hold_q, rdata_hold_d;
    logic                hold_vld_q,   hold_vld_d;

    // Handshake.
    logic mem_ready_go;
    logic advance;
    logic flush;

    // Field views of the latched bus.
    logic        ertn;
    logic [5:0]  ex_type;
    logic [31:0] exe_result;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [9:0]  op;

    // Load datapath.
    logic [31:0] load_raw;
    logic [1:0]  byte_addr;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_aligned;
    logic [31:0] final_result;

    // The stage never waits on anything internal; the SRAM answers in one cycle.
    assign mem_ready_go    = 1'b1;
    assign flush           = wb_ex | ertn_flush;
    assign MEM_to_WB_valid = mem_valid_q & mem_ready_go;
    assign advance         = MEM_to_WB_valid & WB_allow_in;
    assign MEM_allow_in    = ~mem_valid_q | advance;

    assign ertn         = bus_q[109];
    assign ex_type      = bus_q[108:103];
    assign exe_result   = bus_q[102:71];
    assign res_from_mem = bus_q[70];
    assign gr_we        = bus_q[69];
    assign dest         = bus_q[68:64];
    assign op           = bus_q[31:22];

    // Next state: flush kills occupancy but still lets the bus load, and the
    // first-cycle SRAM word is parked while the stage is stalled because the
    // execute stage may reuse the SRAM port meanwhile.
    always_comb begin
        mem_valid_d  = mem_valid_q;
        bus_d        = bus_q;
        rdata_hold_d = rdata_hold_q;
        hold_vld_d   = hold_vld_q;

        if (flush) begin
            mem_valid_d = 1'b0;
        end else if (MEM_allow_in) begin
            mem_valid_d = EXE_to_MEM_valid;
        end

        if (EXE_to_MEM_valid & MEM_allow_in) begin
            bus_d = EXE_to_MEM_bus;
        end

        if (advance | flush) begin
            hold_vld_d = 1'b0;
        end else if (mem_valid_q & ~hold_vld_q) begin
            hold_vld_d   = 1'b1;
            rdata_hold_d = data_sram_rdata;
        end
    end

    // State registers; everything clears asynchronously so outputs go quiet at once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_valid_q  <= 1'b0;
            bus_q        <= '0;
            rdata_hold_q <= '0;
            hold_vld_q   <= 1'b0;
        end else begin
            mem_valid_q  <= mem_valid_d;
            bus_q        <= bus_d;
            rdata_hold_q <= rdata_hold_d;
            hold_vld_q   <= hold_vld_d;
        end
    end

    // Pick the parked word once the first valid cycle has passed.
    assign load_raw  = hold_vld_q ? rdata_hold_q : data_sram_rdata;
    assign byte_addr = exe_result[1:0];

    // Select the addressed byte and halfword out of the raw word.
    always_comb begin
        load_byte = load_raw[7:0];
        case (byte_addr)
            2'd0: load_byte = load_raw[7:0];
            2'd1: load_byte = load_raw[15:8];
            2'd2: load_byte = load_raw[23:16];
            2'd3: load_byte = load_raw[31:24];
            default: load_byte = load_raw[7:0];
        endcase
        load_half = byte_addr[1] ? load_raw[31:16] : load_raw[15:0];
    end

    // Extend according to the load flavour; an unrecognised opcode passes the word.
    always_comb begin
        load_aligned = load_raw;
        case (op)
            OP_LD_B:  load_aligned = {{24{load_byte[7]}}, load_byte};
            OP_LD_H:  load_aligned = {{16{load_half[15]}}, load_half};
            OP_LD_W:  load_aligned = load_raw;
            OP_LD_BU: load_aligned = {24'd0, load_byte};
            OP_LD_HU: load_aligned = {16'd0, load_half};
            default:  load_aligned = load_raw;
        endcase
    end

    assign final_result = res_from_mem ? load_aligned : exe_result;

    // Downstream bus drops res_from_mem and substitutes the final result.
    assign MEM_to_WB_bus = {bus_q[188:103], final_result, bus_q[69:0]};

    // gr_we is forwarded untouched; write-back squashes it on an exception.
    assign MEM_wr_bus = {mem_valid_q & gr_we,
                         mem_valid_q & res_from_mem & LOAD_HAZ,
                         dest,
                         final_result};

    assign MEM_ex   = (|ex_type) & mem_valid_q;
    assign MEM_ertn = ertn & mem_valid_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios with hand-computed results, then
// randomized traffic checked every cycle against a residency-based model.
module tb_mem_stage;

    localparam int BIW = 189;
    localparam int BOW = 188;

    localparam logic [9:0] OP_LDB  = 10'b0010100000;
    localparam logic [9:0] OP_LDH  = 10'b0010100001;
    localparam logic [9:0] OP_LDW  = 10'b0010100010;
    localparam logic [9:0] OP_LDBU = 10'b0010101000;
    localparam logic [9:0] OP_LDHU = 10'b0010101001;
    localparam logic [9:0] OP_ALU  = 10'b0000001010;

`ifdef MEM_LOAD_FWD_EN
    localparam logic EXP_HAZ = 1'b0;
`else
    localparam logic EXP_HAZ = 1'b1;
`endif

    logic           clk = 1'b0;
    logic           resetn;
    logic           EXE_to_MEM_valid;
    logic           MEM_allow_in;
    logic [BIW-1:0] EXE_to_MEM_bus;
    logic [31:0]    data_sram_rdata;
    logic           MEM_to_WB_valid;
    logic           WB_allow_in;
    logic [BOW-1:0] MEM_to_WB_bus;
    logic [38:0]    MEM_wr_bus;
    logic           MEM_ex;
    logic           MEM_ertn;
    logic           wb_ex;
    logic           ertn_flush;

    always #5 clk = ~clk;

    mem_stage #(.BUS_IN_W(BIW), .BUS_OUT_W(BOW)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .EXE_to_MEM_valid(EXE_to_MEM_valid),
        .MEM_allow_in    (MEM_allow_in),
        .EXE_to_MEM_bus  (EXE_to_MEM_bus),
        .data_sram_rdata (data_sram_rdata),
        .MEM_to_WB_valid (MEM_to_WB_valid),
        .WB_allow_in     (WB_allow_in),
        .MEM_to_WB_bus   (MEM_to_WB_bus),
        .MEM_wr_bus      (MEM_wr_bus),
        .MEM_ex          (MEM_ex),
        .MEM_ertn        (MEM_ertn),
        .wb_ex           (wb_ex),
        .ertn_flush      (ertn_flush)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 1'b0;

    // Model: is an instruction resident, is this its first cycle, its bus,
    // and the SRAM word seen during its first cycle.
    bit             m_occ;
    bit             m_first;
    logic [BIW-1:0] m_bus;
    logic [31:0]    m_cap;

    task automatic chk(input string nm, input logic [187:0] act, input logic [187:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    endtask

    function automatic logic [BIW-1:0] mk_bus(input logic [9:0] op, input logic [31:0] exe,
                                              input logic rfm, input logic gwe, input logic [4:0] dest,
                                              input logic [5:0] ext, input logic ertn);
        return {79'h0, ertn, ext, exe, rfm, gwe, dest, 32'h1c00_0100, op, 22'h0};
    endfunction

    function automatic logic [31:0] exp_final(input logic [BIW-1:0] b, input logic [31:0] raw);
        logic [31:0] exe = b[102:71];
        logic [1:0]  a   = exe[1:0];
        logic [31:0] sh  = raw >> {a, 3'b000};
        logic [7:0]  by  = sh[7:0];
        logic [15:0] hw  = a[1] ? raw[31:16] : raw[15:0];
        if (!b[70]) return exe;
        case (b[31:22])
            OP_LDB:  return 32'($signed(by));
            OP_LDH:  return 32'($signed(hw));
            OP_LDBU: return 32'(by);
            OP_LDHU: return 32'(hw);
            default: return raw;
        endcase
    endfunction

    task automatic model_reset();
        m_occ = 0; m_first = 0; m_bus = '0; m_cap = '0;
    endtask

    task automatic model_update();
        bit flush = wb_ex | ertn_flush;
        bit allow = !m_occ || WB_allow_in;
        if (m_occ && m_first) m_cap = data_sram_rdata;
        m_first = 0;
        if (allow && EXE_to_MEM_valid) m_bus = EXE_to_MEM_bus;
        if (flush) m_occ = 0;
        else if (allow) begin
            m_occ   = EXE_to_MEM_valid;
            m_first = EXE_to_MEM_valid;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (resetn) model_update();
        #1;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [31:0] raw;
        logic [31:0] fin;
        if (check_en) begin
            raw = (m_occ && !m_first) ? m_cap : data_sram_rdata;
            fin = exp_final(m_bus, raw);
            chk("allow_in", 188'(MEM_allow_in), 188'(!m_occ || WB_allow_in));
            chk("to_wb_valid", 188'(MEM_to_WB_valid), 188'(m_occ));
            chk("to_wb_bus", 188'(MEM_to_WB_bus), {m_bus[188:103], fin, m_bus[69:0]});
            chk("wr_bus", 188'(MEM_wr_bus),
                188'({m_occ & m_bus[69], m_occ & m_bus[70] & EXP_HAZ, m_bus[68:64], fin}));
            chk("mem_ex", 188'(MEM_ex), 188'(m_occ & (|m_bus[108:103])));
            chk("mem_ertn", 188'(MEM_ertn), 188'(m_occ & m_bus[109]));
        end
    end

    task automatic idle();
        EXE_to_MEM_valid = 0; wb_ex = 0; ertn_flush = 0;
    endtask

    task automatic rand_inputs();
        int          k;
        logic [9:0]  op;
        logic        is_ld;
        EXE_to_MEM_valid = ($urandom_range(0, 99) < 70);
        WB_allow_in      = ($urandom_range(0, 99) < 65);
        wb_ex            = ($urandom_range(0, 99) < 4);
        ertn_flush       = ($urandom_range(0, 99) < 3);
        data_sram_rdata  = $urandom;
        k = int'($urandom_range(0, 6));
        case (k)
            0: op = OP_LDB;
            1: op = OP_LDH;
            2: op = OP_LDW;
            3: op = OP_LDBU;
            4: op = OP_LDHU;
            default: op = OP_ALU;
        endcase
        is_ld = (k < 5);
        EXE_to_MEM_bus = {79'({$urandom, $urandom, $urandom}),
                          1'($urandom_range(0, 19) == 0),
                          ($urandom_range(0, 9) == 0) ? 6'($urandom_range(1, 63)) : 6'd0,
                          32'($urandom), is_ld, 1'($urandom), 5'($urandom),
                          32'($urandom), op, 22'($urandom)};
    endtask

    initial begin
        resetn = 0; idle(); WB_allow_in = 0;
        EXE_to_MEM_bus = '0; data_sram_rdata = 32'h1234_5678;
        model_reset();
        #12;
        chk("rst_allow_in", 188'(MEM_allow_in), 188'(1'b1));
        chk("rst_to_wb_valid", 188'(MEM_to_WB_valid), 188'(1'b0));
        chk("rst_to_wb_bus", 188'(MEM_to_WB_bus), 188'(0));
        chk("rst_wr_bus", 188'(MEM_wr_bus), 188'(0));
        chk("rst_ex_ertn", 188'({MEM_ex, MEM_ertn}), 188'(0));
        @(negedge clk);
        resetn = 1; check_en = 1;

        // ld.b, byte 3 of 0x80FF1234 sign-extended; one cycle in the stage.
        WB_allow_in = 1; EXE_to_MEM_valid = 1;
        EXE_to_MEM_bus = mk_bus(OP_LDB, 32'h1003, 1, 1, 5'd3, 6'd0, 0);
        tick();
        idle(); data_sram_rdata = 32'h80FF_1234;
        @(negedge clk);
        chk("ldb_valid", 188'(MEM_to_WB_valid), 188'(1'b1));
        chk("ldb_result", 188'(MEM_wr_bus[31:0]), 188'(32'hFFFF_FF80));
        tick();
        @(negedge clk);
        chk("ldb_one_cycle", 188'(MEM_to_WB_valid), 188'(1'b0));

        // ld.hu then ld.h on the upper halfword.
        EXE_to_MEM_valid = 1;
        EXE_to_MEM_bus = mk_bus(OP_LDHU, 32'h2002, 1, 1, 5'd4, 6'd0, 0);
        tick();
        EXE_to_MEM_bus = mk_bus(OP_LDH, 32'h2002, 1, 1, 5'd4, 6'd0, 0);
        data_sram_rdata = 32'h9ABC_0000;
        @(negedge clk);
        chk("ldhu_result", 188'(MEM_wr_bus[31:0]), 188'(32'h0000_9ABC));
        tick();
        idle();
        @(negedge clk);
        chk("ldh_result", 188'(MEM_wr_bus[31:0]), 188'(32'hFFFF_9ABC));
        tick();

        // ld.w stalled three cycles while the SRAM word changes.
        WB_allow_in = 0; EXE_to_MEM_valid = 1;
        EXE_to_MEM_bus = mk_bus(OP_LDW, 32'h3000, 1, 1, 5'd6, 6'd0, 0);
        tick();
        idle(); data_sram_rdata = 32'h1111_1111;
        @(negedge clk);
        chk("ldw_first", 188'(MEM_wr_bus[31:0]), 188'(32'h1111_1111));
        tick();
        data_sram_rdata = 32'h2222_2222;
        @(negedge clk);
        chk("ldw_stall_allow", 188'(MEM_allow_in), 188'(1'b0));
        chk("ldw_stall2", 188'(MEM_wr_bus[31:0]), 188'(32'h1111_1111));
        tick();
        @(negedge clk);
        chk("ldw_stall3", 188'(MEM_wr_bus[31:0]), 188'(32'h1111_1111));
        WB_allow_in = 1; #1;
        chk("ldw_release", 188'(MEM_to_WB_bus[101:70]), 188'(32'h1111_1111));
        EXE_to_MEM_valid = 1;
        EXE_to_MEM_bus = mk_bus(OP_LDW, 32'h3004, 1, 1, 5'd6, 6'd0, 0);
        tick();
        idle(); data_sram_rdata = 32'h3333_3333;
        @(negedge clk);
        chk("ldw_hold_cleared", 188'(MEM_wr_bus[31:0]), 188'(32'h3333_3333));
        tick();

        // ALU result forwarding bus, then the load bit for a load.
        EXE_to_MEM_valid = 1;
        EXE_to_MEM_bus = mk_bus(OP_ALU, 32'h42, 0, 1, 5'd5, 6'd0, 0);
        tick();
        EXE_to_MEM_bus = mk_bus(OP_LDW, 32'h4000, 1, 1, 5'd7, 6'd0, 0);
        @(negedge clk);
        chk("alu_wr_bus", 188'(MEM_wr_bus), 188'({1'b1, 1'b0, 5'd5, 32'h42}));
        tick();
        idle();
        @(negedge clk);
        chk("load_haz_bit", 188'(MEM_wr_bus[38:37]), 188'({1'b1, EXP_HAZ}));
        tick();

        // Exception entry, then flush from write-back.
        WB_allow_in = 0; EXE_to_MEM_valid = 1;
        EXE_to_MEM_bus = mk_bus(OP_ALU, 32'h10, 0, 1, 5'd8, 6'b000001, 0);
        tick();
        idle();
        @(negedge clk);
        chk("ex_set", 188'(MEM_ex), 188'(1'b1));
        wb_ex = 1;
        tick();
        wb_ex = 0;
        @(negedge clk);
        chk("ex_flush", 188'({MEM_to_WB_valid, MEM_ex, MEM_allow_in}), 188'(3'b001));

        // ERTN indication, then flush racing with a new entry.
        WB_allow_in = 1; EXE_to_MEM_valid = 1;
        EXE_to_MEM_bus = mk_bus(OP_ALU, 32'h20, 0, 0, 5'd0, 6'd0, 1);
        tick();
        idle();
        @(negedge clk);
        chk("ertn_set", 188'(MEM_ertn), 188'(1'b1));
        EXE_to_MEM_valid = 1; ertn_flush = 1;
        EXE_to_MEM_bus = mk_bus(OP_ALU, 32'h24, 0, 1, 5'd9, 6'd0, 0);
        tick();
        idle();
        @(negedge clk);
        chk("flush_vs_entry", 188'(MEM_to_WB_valid), 188'(1'b0));

        // Asynchronous reset while a load is stalled.
        WB_allow_in = 0; EXE_to_MEM_valid = 1;
        EXE_to_MEM_bus = mk_bus(OP_LDB, 32'h5001, 1, 1, 5'd10, 6'd2, 1);
        tick();
        idle(); data_sram_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("pre_rst_valid", 188'(MEM_to_WB_valid), 188'(1'b1));
        #2;
        resetn = 0; model_reset();
        #1;
        chk("async_rst_quiet", 188'({MEM_to_WB_valid, MEM_to_WB_bus, MEM_wr_bus, MEM_ex, MEM_ertn}), 188'(0));
        chk("async_rst_allow", 188'(MEM_allow_in), 188'(1'b1));
        @(negedge clk);
        resetn = 1;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            tick();
        end
        idle();
        @(negedge clk);
        check_en = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
